instruction_memory_loader: RTL and testbench

Parametrised next-generation instruction memory with a built-in block-load engine and a registered fetch port.
- The loader accepts a burst of instruction words over a valid/ready stream and writes them to consecutive addresses from a programmable base.
- The CPU fetch port reads with fixed 1-cycle latency and is stalled while a load is in progress.
- Sits between the boot/debug loader and the fetch stage of the 16-bit CPU.

---
 rtl/instr_mem_pkg.sv | 19 +
 rtl/instr_mem_load_ctrl.sv | 114 +++++++++++
 rtl/instruction_memory_loader.sv | 119 +++++++++++
 tb/tb_instruction_memory_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory and its block-load engine.
//   load_state_e : loader FSM encoding (IDLE, LOAD, DONE)
//   NOP_WORD     : word returned for out-of-range fetches
//   ptr_width()  : index width needed to address a DEPTH-word array
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam int unsigned NOP_WORD = 0;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_load_ctrl.sv
// Block-load engine: accepts a burst of words on a valid/ready stream and
// issues writes to consecutive (wrapping) addresses from a programmable base.
// Optional macro INSTR_MEM_LOAD_CHECKSUM_EN adds a running XOR checksum output.
// Ports:
//   clk, rst                   clock, async active-high reset
//   load_start/base/count      burst request (sampled in IDLE only)
//   load_data/valid/ready      stream handshake
//   load_busy, load_done       status (state != IDLE, one-cycle completion pulse)
//   wr_en, wr_addr, wr_data    write port towards the storage array
//   load_checksum              XOR of accepted beats (macro only)
module instr_mem_load_ctrl
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [CNT_W-1:0]  load_count,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              wr_en,
  output logic [PTR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_checksum
`endif
);

  load_state_e       state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              beat;

  // Status outputs decode the state register directly
  assign load_ready = (state_q == LOAD);
  assign load_done  = (state_q == DONE);
  assign load_busy  = (state_q != IDLE);
  assign beat       = load_ready && load_valid;

  assign wr_en   = beat;
  assign wr_addr = ptr_q;
  assign wr_data = load_data;

  // Next-state, pointer and remaining-count logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_count != CNT_W'(0)) begin
            // DEPTH is a power of two, so keeping the low bits is base mod DEPTH
            ptr_d   = PTR_W'(load_base);
            rem_d   = load_count;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          ptr_d = ptr_q + PTR_W'(1);  // natural wrap at DEPTH
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Cleared on an accepted start, folded with every accepted beat
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && load_start) csum_d = '0;
    else if (beat)                      csum_d = csum_q ^ load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign load_checksum = csum_q;
`endif

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a block-load engine and a registered fetch port.
// Fetches are accepted only while the loader is idle, so reads and writes
// never collide. Optional macro INSTR_MEM_LOAD_CHECKSUM_EN adds load_checksum.
// Ports:
//   clk, rst                              clock, async active-high reset
//   fetch_en, fetch_addr                  fetch request
//   instruction_out/valid, fetch_fault    registered fetch result (1-cycle latency)
//   load_start/base/count/data/valid      loader request and stream
//   load_ready, load_busy, load_done      loader status
//   load_checksum                         XOR of burst data (macro only)
module instruction_memory_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction_out,
  output logic              instruction_valid,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [CNT_W-1:0]  load_count,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_checksum
`endif
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CMP_W = ADDR_W + 1;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              in_range;

  instr_mem_load_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    ,
    .load_checksum (load_checksum)
`endif
  );

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Extra bit keeps the compare correct when DEPTH == 2**ADDR_W
  assign in_range = ({1'b0, fetch_addr} < CMP_W'(DEPTH));

  // Fetch result; instruction_out holds when no fetch is accepted
  always_comb begin
    instr_d = instr_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    if (fetch_en && !load_busy) begin
      valid_d = 1'b1;
      if (in_range) begin
        instr_d = mem[PTR_W'(fetch_addr)];
      end else begin
        instr_d = DATA_W'(NOP_WORD);
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign instruction_out   = instr_q;
  assign instruction_valid = valid_q;
  assign fetch_fault       = fault_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader (DEPTH=256 defaults).
module tb_instruction_memory_loader;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [15:0] fetch_addr;
  logic [15:0] instruction_out;
  logic        instruction_valid;
  logic        fetch_fault;
  logic        load_start;
  logic [15:0] load_base;
  logic [15:0] load_count;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  logic [15:0] load_checksum;
`endif

  instruction_memory_loader dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_en          (fetch_en),
    .fetch_addr        (fetch_addr),
    .instruction_out   (instruction_out),
    .instruction_valid (instruction_valid),
    .fetch_fault       (fetch_fault),
    .load_start        (load_start),
    .load_base         (load_base),
    .load_count        (load_count),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_busy         (load_busy),
    .load_done         (load_done)
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    ,
    .load_checksum     (load_checksum)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model [0:255];
  logic [15:0] ld_data [0:7];
  int          vectors = 0;
  int          miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented fetch result against the scoreboard
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (instruction_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(instruction_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("instruction_out", 32'(instruction_out), 32'(e.data));
          check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
        end
      end else if (fetch_fault) begin
        check("fault_without_valid", 32'(fetch_fault), 32'd0);
      end
    end
  end

  // Issue back-to-back fetches over n consecutive addresses
  task automatic fetch_run(input logic [15:0] addr, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fetch_en   = 1'b1;
      fetch_addr = addr + 16'(i);
      if (fetch_addr < 16'd256) begin
        e.data  = model[fetch_addr[7:0]];
        e.fault = 1'b0;
      end else begin
        e.data  = 16'h0000;
        e.fault = 1'b1;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  // Run a burst; nsend < cnt aborts after nsend beats (caller then resets)
  task automatic do_load(input logic [15:0] base, input logic [15:0] cnt, input int nsend,
                         input bit gaps, input bit hold_fetch);
    int          sent, rdy, done_seen;
    bit          gap_now, finished;
    logic [15:0] csum;
    sent = 0; rdy = 0; done_seen = 0; gap_now = gaps; finished = 0; csum = 16'h0;
    @(negedge clk);
    load_start = 1'b1; load_base = base; load_count = cnt;
    @(negedge clk);
    load_start = 1'b0;
    fetch_en   = hold_fetch;
    fetch_addr = 16'h0010;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (load_done) begin done_seen = 1; finished = 1; break; end
      if (sent == nsend && nsend < int'(cnt)) begin finished = 1; break; end
      load_valid = 1'b0;
      if (load_ready) begin
        rdy++;
        if (gap_now) begin
          gap_now = 1'b0;
        end else begin
          load_valid = 1'b1;
          load_data  = ld_data[sent];
          model[8'(base + 16'(sent))] = ld_data[sent];
          csum = csum ^ ld_data[sent];
          sent++;
          gap_now = gaps;
        end
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    fetch_en   = 1'b0;
    if (!finished) check("load_timeout", 32'd1, 32'd0);
    if (nsend < int'(cnt)) return;
    check("load_done_seen", 32'(done_seen), 32'd1);
    check("ready_cycles", 32'(rdy), gaps ? 32'(2 * int'(cnt)) : 32'(cnt));
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    check("load_checksum", 32'(load_checksum), 32'(csum));
`endif
    @(negedge clk);
    check("load_done_pulse", 32'(load_done), 32'd0);
    check("load_busy_after", 32'(load_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_base = '0; load_count = '0; load_data = '0; load_valid = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    #2;
    check("rst_instruction_valid", 32'(instruction_valid), 32'd0);
    check("rst_instruction_out", 32'(instruction_out), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_busy", 32'(load_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a 4-beat burst at base 0
    ld_data[0] = 16'hA0A0; ld_data[1] = 16'hB1B1; ld_data[2] = 16'hC2C2; ld_data[3] = 16'hD3D3;
    do_load(16'h0000, 16'd4, 2, 1'b0, 1'b0);
    check("midload_busy_before_rst", 32'(load_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_load_ready", 32'(load_ready), 32'd0);
    check("abort_load_busy", 32'(load_busy), 32'd0);
    check("abort_load_done", 32'(load_done), 32'd0);
    check("abort_instruction_valid", 32'(instruction_valid), 32'd0);
    check("abort_fetch_fault", 32'(fetch_fault), 32'd0);
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    check("abort_checksum", 32'(load_checksum), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    fetch_run(16'h0000, 2);   // expects 0xA0A0, 0xB1B1

    // Continuous 3-beat burst at 0x0010
    ld_data[0] = 16'h1111; ld_data[1] = 16'h2222; ld_data[2] = 16'h3333;
    do_load(16'h0010, 16'd3, 3, 1'b0, 1'b0);
    fetch_run(16'h0010, 3);

    // Wrap from DEPTH-1 to 0
    ld_data[0] = 16'hAAAA; ld_data[1] = 16'hBBBB;
    do_load(16'h00FF, 16'd2, 2, 1'b0, 1'b0);
    check("wrap_model_ff", 32'(model[255]), 32'h0000AAAA);
    check("wrap_model_00", 32'(model[0]), 32'h0000BBBB);
    fetch_run(16'h00FF, 1);
    fetch_run(16'h0000, 2);   // 0xBBBB then untouched 0xB1B1

    // Zero-length burst: done pulse only, memory untouched
    do_load(16'h0010, 16'd0, 0, 1'b0, 1'b0);
    fetch_run(16'h0010, 1);

    // Fetch held high during a burst must never produce a result
    ld_data[0] = 16'h5555; ld_data[1] = 16'h6666;
    do_load(16'h0020, 16'd2, 2, 1'b0, 1'b1);
    fetch_run(16'h0020, 2);

    // Out-of-range fetch returns NOP with fault
    fetch_run(16'h0100, 1);
    fetch_run(16'hFFFF, 1);

    // Burst with a bubble before every beat; checksum 0x1DCB when enabled
    ld_data[0] = 16'h00F0; ld_data[1] = 16'h0F0F; ld_data[2] = 16'h1234;
    do_load(16'h0040, 16'd3, 3, 1'b1, 1'b0);
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    check("checksum_holds", 32'(load_checksum), 32'h00001DCB);
`endif
    fetch_run(16'h0040, 3);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
